// File: rtl/mux_pkg.sv
// Shared types and defaults for the N:1 round-robin stream multiplexer.
package mux_pkg;

    typedef enum logic {
        MUX_MANUAL = 1'b0,
        MUX_RR     = 1'b1
    } mux_mode_e;

    localparam int MUX_DEF_N = 4;
    localparam int MUX_DEF_W = 8;

endpackage : mux_pkg

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: rotates the request vector so that
// index ptr lands at bit 0, priority-encodes the lowest set bit, then maps
// the offset back to an absolute channel index.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int SW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [SW-1:0] ptr,
    output logic          gnt_valid,
    output logic [SW-1:0] gnt_idx
);

    logic [2*N-1:0] w_req2;
    logic [N-1:0]   w_rot;
    int             w_off;
    int             w_sum;

    // Rotate right by ptr (doubling the vector makes the wrap free), then
    // scan from the highest offset down so the lowest offset wins.
    always_comb begin
        w_req2    = {req, req};
        w_rot     = N'(w_req2 >> ptr);
        gnt_valid = 1'b0;
        w_off     = 0;
        for (int j = N - 1; j >= 0; j--) begin
            if (w_rot[j]) begin
                gnt_valid = 1'b1;
                w_off     = j;
            end
        end
        w_sum = int'(ptr) + w_off;
        if (w_sum >= N) begin
            w_sum = w_sum - N;
        end
        gnt_idx = SW'(w_sum);
    end

endmodule : rr_arbiter

// File: rtl/mux_nx1_rr.sv
// N:1, W-bit stream multiplexer with valid/ready handshake, one registered
// output stage and MANUAL / ROUND_ROBIN channel selection.
// Optional feature: define MUX_PARITY_EN to add the registered out_par port
// (even parity of out_data).
module mux_nx1_rr
    import mux_pkg::*;
#(
    parameter int N  = MUX_DEF_N,
    parameter int W  = MUX_DEF_W,
    parameter int SW = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           mode,
    input  logic [SW-1:0]  sel,
    input  logic [N*W-1:0] in_data,
    input  logic [N-1:0]   in_valid,
    output logic [N-1:0]   in_ready,
    output logic [W-1:0]   out_data,
    output logic [SW-1:0]  out_ch,
    output logic           out_valid,
    input  logic           out_ready
`ifdef MUX_PARITY_EN
    ,
    output logic           out_par
`endif
);

    logic [W-1:0]  r_out_data;
    logic [SW-1:0] r_out_ch;
    logic          r_out_valid;
    logic [SW-1:0] r_rr_ptr;
`ifdef MUX_PARITY_EN
    logic          r_out_par;
`endif

    logic          w_load_ok;
    logic          w_man_valid;
    logic          w_rr_valid;
    logic [SW-1:0] w_rr_idx;
    logic          w_gnt_valid;
    logic [SW-1:0] w_gnt_idx;
    logic          w_xfer;
    logic [W-1:0]  w_sel_data;
    logic [SW-1:0] w_ptr_next;
    logic          w_is_rr;

    rr_arbiter #(
        .N  (N),
        .SW (SW)
    ) u_arb (
        .req       (in_valid),
        .ptr       (r_rr_ptr),
        .gnt_valid (w_rr_valid),
        .gnt_idx   (w_rr_idx)
    );

    assign w_is_rr   = (mux_mode_e'(mode) == MUX_RR);
    // The register can take a word when empty or when it is draining now.
    assign w_load_ok = ~r_out_valid | out_ready;

    // Manual grant: sel must name an existing channel whose valid is high;
    // an out-of-range sel matches no channel and so never grants.
    always_comb begin
        w_man_valid = 1'b0;
        for (int g = 0; g < N; g++) begin
            if ((sel == SW'(g)) && in_valid[g]) begin
                w_man_valid = 1'b1;
            end
        end
    end

    // Pick the active grant source for this cycle from the current mode.
    always_comb begin
        if (w_is_rr) begin
            w_gnt_valid = w_rr_valid;
            w_gnt_idx   = w_rr_idx;
        end else begin
            w_gnt_valid = w_man_valid;
            w_gnt_idx   = sel;
        end
    end

    assign w_xfer = ~rst & w_gnt_valid & w_load_ok;

    // One-hot ready towards the granted channel, plus the data select.
    always_comb begin
        in_ready   = '0;
        w_sel_data = '0;
        for (int g = 0; g < N; g++) begin
            if (w_gnt_idx == SW'(g)) begin
                in_ready[g] = w_xfer;
                w_sel_data  = in_data[g*W +: W];
            end
        end
    end

    assign w_ptr_next = (w_gnt_idx == SW'(N - 1)) ? '0 : w_gnt_idx + 1'b1;

    // Output register and round-robin pointer: load on transfer, clear valid
    // on a drain with nothing to replace it, hold everything on stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_ch    <= '0;
            r_rr_ptr    <= '0;
`ifdef MUX_PARITY_EN
            r_out_par   <= 1'b0;
`endif
        end else if (w_xfer) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_sel_data;
            r_out_ch    <= w_gnt_idx;
`ifdef MUX_PARITY_EN
            r_out_par   <= ^w_sel_data;
`endif
            if (w_is_rr) begin
                r_rr_ptr <= w_ptr_next;
            end
        end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_data  = r_out_data;
    assign out_ch    = r_out_ch;
    assign out_valid = r_out_valid;
`ifdef MUX_PARITY_EN
    assign out_par   = r_out_par;
`endif

endmodule : mux_nx1_rr

// File: tb/tb_mux_nx1_rr.sv
// Directed bench for mux_nx1_rr: a default N=4/W=8 instance plus an N=6
// instance for out-of-range select. Parity checks build with MUX_PARITY_EN.
module tb_mux_nx1_rr;

    logic        clk = 1'b0;
    logic        rst;
    logic        mode;
    logic [1:0]  sel;
    logic [31:0] in_data;
    logic [3:0]  in_valid;
    logic [3:0]  in_ready;
    logic [7:0]  out_data;
    logic [1:0]  out_ch;
    logic        out_valid;
    logic        out_ready;
`ifdef MUX_PARITY_EN
    logic        out_par;
`endif

    logic        mode6;
    logic [2:0]  sel6;
    logic [47:0] data6;
    logic [5:0]  valid6;
    logic [5:0]  ready6;
    logic [7:0]  od6;
    logic [2:0]  oc6;
    logic        ov6;
    logic        or6;
`ifdef MUX_PARITY_EN
    logic        op6;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mux_nx1_rr #(.N(4), .W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode),
        .sel       (sel),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_ch    (out_ch),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef MUX_PARITY_EN
        ,
        .out_par   (out_par)
`endif
    );

    mux_nx1_rr #(.N(6), .W(8)) dut6 (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode6),
        .sel       (sel6),
        .in_data   (data6),
        .in_valid  (valid6),
        .in_ready  (ready6),
        .out_data  (od6),
        .out_ch    (oc6),
        .out_valid (ov6),
        .out_ready (or6)
`ifdef MUX_PARITY_EN
        ,
        .out_par   (op6)
`endif
    );

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1; mode = 1'b1; out_ready = 1'b1; in_valid = 4'hF;
        mode6 = 1'b1; or6 = 1'b1; valid6 = 6'h3F;
        #1;
        n_cmp++; if (in_ready !== 4'h0) begin n_fail++; $display("FAIL rst_in_ready: got %h expected 0", in_ready); end
        n_cmp++; if (ready6 !== 6'h0) begin n_fail++; $display("FAIL rst_ready6: got %h expected 0", ready6); end
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b expected 0", out_valid); end
            n_cmp++; if (out_data !== 8'h00) begin n_fail++; $display("FAIL rst_out_data: got %h expected 00", out_data); end
            n_cmp++; if (out_ch !== 2'd0) begin n_fail++; $display("FAIL rst_out_ch: got %0d expected 0", out_ch); end
            n_cmp++; if (in_ready !== 4'h0) begin n_fail++; $display("FAIL rst_hold_ready: got %h expected 0", in_ready); end
        end
        rst = 1'b0; in_valid = 4'h0; valid6 = 6'h0;
        @(negedge clk);
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL idle_out_valid: got %b expected 0", out_valid); end
        n_cmp++; if (ov6 !== 1'b0) begin n_fail++; $display("FAIL idle_ov6: got %b expected 0", ov6); end
    endtask

    task automatic test_manual();
        mode = 1'b0; sel = 2'd2; out_ready = 1'b1;
        in_data = {8'h44, 8'hA5, 8'h22, 8'h11};
        in_valid = 4'b0100;
        #1;
        n_cmp++; if (in_ready !== 4'b0100) begin n_fail++; $display("FAIL man_ready: got %b expected 0100", in_ready); end
        @(negedge clk);
        n_cmp++; if (out_data !== 8'hA5) begin n_fail++; $display("FAIL man_data: got %h expected a5", out_data); end
        n_cmp++; if (out_ch !== 2'd2) begin n_fail++; $display("FAIL man_ch: got %0d expected 2", out_ch); end
        n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL man_valid: got %b expected 1", out_valid); end
        // sel points at an idle channel while another one is valid
        sel = 2'd1;
        #1;
        n_cmp++; if (in_ready !== 4'b0000) begin n_fail++; $display("FAIL man_nogrant: got %b expected 0000", in_ready); end
        @(negedge clk);
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL man_drain: got %b expected 0", out_valid); end
        n_cmp++; if (out_data !== 8'hA5) begin n_fail++; $display("FAIL man_drain_hold: got %h expected a5", out_data); end
        n_cmp++; if (out_ch !== 2'd2) begin n_fail++; $display("FAIL man_drain_ch: got %0d expected 2", out_ch); end
        in_valid = 4'h0;
    endtask

    task automatic test_sel_range();
        mode6 = 1'b0; or6 = 1'b1;
        data6 = {8'hF5, 8'hE4, 8'hD3, 8'hC2, 8'hB1, 8'hA0};
        sel6 = 3'd5; valid6 = 6'h00;
        #1;
        n_cmp++; if (ready6 !== 6'h00) begin n_fail++; $display("FAIL sel5_novalid: got %b expected 000000", ready6); end
        sel6 = 3'd7; valid6 = 6'h3F;
        #1;
        n_cmp++; if (ready6 !== 6'h00) begin n_fail++; $display("FAIL sel7_oob: got %b expected 000000", ready6); end
        @(negedge clk);
        n_cmp++; if (ov6 !== 1'b0) begin n_fail++; $display("FAIL sel7_no_load: got %b expected 0", ov6); end
        sel6 = 3'd5;
        #1;
        n_cmp++; if (ready6 !== 6'b100000) begin n_fail++; $display("FAIL sel5_ready: got %b expected 100000", ready6); end
        @(negedge clk);
        n_cmp++; if (oc6 !== 3'd5) begin n_fail++; $display("FAIL sel5_ch: got %0d expected 5", oc6); end
        n_cmp++; if (od6 !== 8'hF5) begin n_fail++; $display("FAIL sel5_data: got %h expected f5", od6); end
        valid6 = 6'h00;
        @(negedge clk);
    endtask

    task automatic test_rr_fairness();
        logic [1:0] exp_ch;
        mode = 1'b1; out_ready = 1'b1;
        in_data = {8'h13, 8'h12, 8'h11, 8'h10};
        in_valid = 4'hF;
        #1;
        n_cmp++; if (in_ready !== 4'b0001) begin n_fail++; $display("FAIL rr_first_ready: got %b expected 0001", in_ready); end
        for (int k = 0; k < 6; k++) begin
            exp_ch = 2'(k % 4);
            @(negedge clk);
            n_cmp++; if (out_ch !== exp_ch) begin n_fail++; $display("FAIL rr_ch[%0d]: got %0d expected %0d", k, out_ch, exp_ch); end
            n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL rr_valid[%0d]: got %b expected 1", k, out_valid); end
            n_cmp++; if (out_data !== {6'h04, exp_ch}) begin n_fail++; $display("FAIL rr_data[%0d]: got %h expected %h", k, out_data, {6'h04, exp_ch}); end
        end
        in_valid = 4'h0;
        @(negedge clk);
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rr_drain: got %b expected 0", out_valid); end
    endtask

    task automatic test_backpressure();
        mode = 1'b0; sel = 2'd1; out_ready = 1'b1;
        in_data = {8'h00, 8'h00, 8'h3C, 8'h00};
        in_valid = 4'b0010;
        @(negedge clk);
        n_cmp++; if (out_data !== 8'h3C) begin n_fail++; $display("FAIL bp_load: got %h expected 3c", out_data); end
        out_ready = 1'b0;
        in_data = {8'h00, 8'h00, 8'h5A, 8'h00};
        for (int c = 0; c < 3; c++) begin
            #1;
            n_cmp++; if (in_ready !== 4'h0) begin n_fail++; $display("FAIL bp_ready[%0d]: got %b expected 0000", c, in_ready); end
            @(negedge clk);
            n_cmp++; if (out_data !== 8'h3C) begin n_fail++; $display("FAIL bp_hold[%0d]: got %h expected 3c", c, out_data); end
            n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid[%0d]: got %b expected 1", c, out_valid); end
        end
        out_ready = 1'b1;
        #1;
        n_cmp++; if (in_ready !== 4'b0010) begin n_fail++; $display("FAIL bp_release_ready: got %b expected 0010", in_ready); end
        @(negedge clk);
        n_cmp++; if (out_data !== 8'h5A) begin n_fail++; $display("FAIL bp_reload: got %h expected 5a", out_data); end
        in_valid = 4'h0;
        @(negedge clk);
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drain: got %b expected 0", out_valid); end
    endtask

    task automatic test_wrap_skip();
        mode = 1'b1; out_ready = 1'b1;
        in_data = {8'h83, 8'h82, 8'h81, 8'h80};
        in_valid = 4'b0100;
        #1;
        n_cmp++; if (in_ready !== 4'b0100) begin n_fail++; $display("FAIL ws_ch2_ready: got %b expected 0100", in_ready); end
        @(negedge clk);
        in_valid = 4'b0011;
        #1;
        n_cmp++; if (in_ready !== 4'b0001) begin n_fail++; $display("FAIL ws_wrap_ready: got %b expected 0001", in_ready); end
        @(negedge clk);
        n_cmp++; if (out_ch !== 2'd0) begin n_fail++; $display("FAIL ws_ch0: got %0d expected 0", out_ch); end
        #1;
        n_cmp++; if (in_ready !== 4'b0010) begin n_fail++; $display("FAIL ws_next_ready: got %b expected 0010", in_ready); end
        @(negedge clk);
        n_cmp++; if (out_ch !== 2'd1) begin n_fail++; $display("FAIL ws_ch1: got %0d expected 1", out_ch); end
        // stall, then flip mode while the ch1 word is held
        out_ready = 1'b0; mode = 1'b0; sel = 2'd0;
        #1;
        n_cmp++; if (in_ready !== 4'h0) begin n_fail++; $display("FAIL ws_switch_ready: got %b expected 0000", in_ready); end
        @(negedge clk);
        n_cmp++; if (out_data !== 8'h81) begin n_fail++; $display("FAIL ws_switch_data: got %h expected 81", out_data); end
        n_cmp++; if (out_ch !== 2'd1) begin n_fail++; $display("FAIL ws_switch_ch: got %0d expected 1", out_ch); end
        out_ready = 1'b1; in_valid = 4'h0;
        @(negedge clk);
    endtask

`ifdef MUX_PARITY_EN
    task automatic test_parity();
        mode = 1'b0; sel = 2'd0; out_ready = 1'b1;
        in_data = {24'h0, 8'h07}; in_valid = 4'b0001;
        @(negedge clk);
        n_cmp++; if (out_par !== 1'b1) begin n_fail++; $display("FAIL par_07: got %b expected 1", out_par); end
        in_data = {24'h0, 8'h03};
        @(negedge clk);
        n_cmp++; if (out_par !== 1'b0) begin n_fail++; $display("FAIL par_03: got %b expected 0", out_par); end
        in_valid = 4'h0;
        @(negedge clk);
        n_cmp++; if (out_par !== 1'b0) begin n_fail++; $display("FAIL par_hold: got %b expected 0", out_par); end
    endtask
`endif

    task automatic test_midstream_reset();
        mode = 1'b1; out_ready = 1'b1;
        in_data = {8'h63, 8'h62, 8'h61, 8'h60};
        in_valid = 4'b1000;
        @(negedge clk);
        n_cmp++; if (out_ch !== 2'd3) begin n_fail++; $display("FAIL mr_load_ch: got %0d expected 3", out_ch); end
        rst = 1'b1; in_valid = 4'hF;
        #1;
        n_cmp++; if (in_ready !== 4'h0) begin n_fail++; $display("FAIL mr_ready: got %b expected 0000", in_ready); end
        @(negedge clk);
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mr_valid: got %b expected 0", out_valid); end
        rst = 1'b0;
        #1;
        n_cmp++; if (in_ready !== 4'b0001) begin n_fail++; $display("FAIL mr_ptr: got %b expected 0001", in_ready); end
        @(negedge clk);
        n_cmp++; if (out_data !== 8'h60) begin n_fail++; $display("FAIL mr_after: got %h expected 60", out_data); end
        in_valid = 4'h0;
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; mode = 1'b0; sel = '0; in_data = '0; in_valid = '0; out_ready = 1'b0;
        mode6 = 1'b0; sel6 = '0; data6 = '0; valid6 = '0; or6 = 1'b0;
        test_reset();
        test_manual();
        test_sel_range();
        test_rr_fairness();
        test_backpressure();
        test_wrap_skip();
`ifdef MUX_PARITY_EN
        test_parity();
`endif
        test_midstream_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_mux_nx1_rr
